// File: rtl/uart_top_if.sv
// rtl/uart_top_if.sv - register write strobes and readback bus between CPU side and uart_top
interface uart_top_if;
  logic        uart_baud_wr;
  logic        uart_con_wr;
  logic        uart_txbuf_wr;
  logic [15:0] icb_wdat;
  logic [15:0] uart_con;
  logic [15:0] uart_baud;
  logic [15:0] uart_txbuf;

  modport master (
    output uart_baud_wr, uart_con_wr, uart_txbuf_wr, icb_wdat,
    input  uart_con, uart_baud, uart_txbuf
  );

  modport slave (
    input  uart_baud_wr, uart_con_wr, uart_txbuf_wr, icb_wdat,
    output uart_con, uart_baud, uart_txbuf
  );
endinterface

// File: rtl/uart_top.sv
// rtl/uart_top.sv - register-mapped 8N1 UART with TX/RX state machines and level interrupt
module uart_top (
  input  logic      sys_clk,
  input  logic      sys_rst,
  uart_top_if.slave bus,
  input  logic      uart_rx,
  output logic      uart_tx,
  output logic      uart_en,
  output logic      uart_int
);
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t      r_tx_state, w_tx_state_nxt;
  state_t      r_rx_state, w_rx_state_nxt;
  logic [15:0] r_baud;
  logic        r_en, r_tx_ie, r_rx_ie;
  logic        r_rx_ferr, r_rx_pend, r_tx_pend;
  logic [7:0]  r_tx_data, r_tx_shift, r_rx_data, r_rx_shift;
  logic [15:0] r_tx_div, r_tx_cnt, r_rx_div, r_rx_cnt;
  logic [2:0]  r_tx_bit, r_rx_bit;
  logic        r_tx, r_int;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;

  logic        w_en_nxt, w_abort, w_tx_busy, w_tx_load, w_tx_go, w_tx_tick, w_tx_done;
  logic        w_rx_fall, w_rx_tick, w_rx_mid, w_rx_stop, w_rx_ok, w_rx_bad;
  logic [16:0] w_rx_half;

  // Clearing en aborts both directions on the very edge that samples the write.
  assign w_en_nxt  = bus.uart_con_wr ? bus.icb_wdat[0] : r_en;
  assign w_abort   = !w_en_nxt;
  assign w_tx_busy = (r_tx_state != ST_IDLE);
  assign w_tx_load = bus.uart_txbuf_wr && !w_tx_busy;
  assign w_tx_go   = w_tx_load && r_en;
  assign w_tx_tick = (r_tx_cnt == r_tx_div);
  assign w_tx_done = (r_tx_state == ST_STOP) && w_tx_tick && !w_abort;

  assign w_rx_half = ({1'b0, r_rx_div} + 17'd1) >> 1;
  assign w_rx_fall = r_rx_prev && !r_rx_s2;
  assign w_rx_tick = (r_rx_cnt == r_rx_div);
  assign w_rx_mid  = ({1'b0, r_rx_cnt} == w_rx_half);
  assign w_rx_stop = (r_rx_state == ST_STOP) && w_rx_tick && !w_abort;
  assign w_rx_ok   = w_rx_stop && r_rx_s2;
  assign w_rx_bad  = w_rx_stop && !r_rx_s2;

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      ST_IDLE:  if (w_tx_go) w_tx_state_nxt = ST_START;
      ST_START: if (w_tx_tick) w_tx_state_nxt = ST_DATA;
      ST_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_state_nxt = ST_STOP;
      ST_STOP:  if (w_tx_tick) w_tx_state_nxt = ST_IDLE;
      default:  w_tx_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_tx_state_nxt = ST_IDLE;
  end

  // A zero divisor has no half-bit to wait for, so detection goes straight to data.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      ST_IDLE:  if (r_en && w_rx_fall) w_rx_state_nxt = (r_baud == 16'd0) ? ST_DATA : ST_START;
      ST_START: if (w_rx_mid) w_rx_state_nxt = r_rx_s2 ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_state_nxt = ST_STOP;
      ST_STOP:  if (w_rx_tick) w_rx_state_nxt = ST_IDLE;
      default:  w_rx_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_rx_state_nxt = ST_IDLE;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_tx_state <= ST_IDLE;
      r_rx_state <= ST_IDLE;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_rx_state <= w_rx_state_nxt;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_tx_data  <= 8'd0;
      r_tx_shift <= 8'd0;
      r_tx_div   <= 16'd0;
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 3'd0;
      r_tx       <= 1'b1;
    end else begin
      if (w_tx_load) r_tx_data <= bus.icb_wdat[7:0];
      case (r_tx_state)
        ST_IDLE: begin
          if (w_tx_go) begin
            r_tx       <= 1'b0;
            r_tx_div   <= r_baud;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= bus.icb_wdat[7:0];
          end
        end
        ST_START: begin
          if (w_tx_tick) begin
            r_tx_cnt <= 16'd0;
            r_tx     <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (w_tx_tick) begin
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx_shift <= r_tx_shift >> 1;
            r_tx       <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_shift[1];
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        default: begin
          r_tx_cnt <= w_tx_tick ? 16'd0 : r_tx_cnt + 16'd1;
        end
      endcase
      if (w_abort) r_tx <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_div   <= 16'd0;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
      r_rx_data  <= 8'd0;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        ST_IDLE: begin
          if (r_en && w_rx_fall) begin
            r_rx_div <= r_baud;
            r_rx_cnt <= (r_baud == 16'd0) ? 16'd0 : 16'd1;
            r_rx_bit <= 3'd0;
          end
        end
        ST_START: begin
          r_rx_cnt <= w_rx_mid ? 16'd0 : r_rx_cnt + 16'd1;
        end
        ST_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= r_rx_bit + 3'd1;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: begin
          r_rx_cnt <= w_rx_tick ? 16'd0 : r_rx_cnt + 16'd1;
          if (w_rx_ok) r_rx_data <= r_rx_shift;
        end
      endcase
    end
  end

  // Hardware set beats a same-cycle write-1-to-clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_baud    <= 16'd0;
      r_en      <= 1'b0;
      r_tx_ie   <= 1'b0;
      r_rx_ie   <= 1'b0;
      r_tx_pend <= 1'b0;
      r_rx_pend <= 1'b0;
      r_rx_ferr <= 1'b0;
      r_int     <= 1'b0;
    end else begin
      if (bus.uart_baud_wr) r_baud <= bus.icb_wdat;
      if (bus.uart_con_wr) begin
        r_en    <= bus.icb_wdat[0];
        r_tx_ie <= bus.icb_wdat[1];
        r_rx_ie <= bus.icb_wdat[2];
      end
      r_tx_pend <= w_tx_done | (r_tx_pend & !(bus.uart_con_wr & bus.icb_wdat[15]));
      r_rx_pend <= w_rx_ok   | (r_rx_pend & !(bus.uart_con_wr & bus.icb_wdat[14]));
      r_rx_ferr <= w_rx_bad  | (r_rx_ferr & !(bus.uart_con_wr & bus.icb_wdat[12]));
      r_int     <= r_en & ((r_tx_pend & r_tx_ie) | (r_rx_pend & r_rx_ie));
    end
  end

  assign bus.uart_con   = {r_tx_pend, r_rx_pend, w_tx_busy, r_rx_ferr, 9'd0, r_rx_ie, r_tx_ie, r_en};
  assign bus.uart_baud  = r_baud;
  assign bus.uart_txbuf = {r_rx_data, r_tx_data};
  assign uart_tx        = r_tx;
  assign uart_en        = r_en;
  assign uart_int       = r_int;
endmodule

// File: tb/tb_uart_top.sv
// tb/tb_uart_top.sv - self-checking bench for uart_top: register vectors, TX/RX frames, corner cases
module tb_uart_top;
  logic sys_clk = 1'b0;
  logic sys_rst;
  logic uart_rx, uart_tx, uart_en, uart_int;

  uart_top_if bus();

  uart_top dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .bus      (bus),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .uart_en  (uart_en),
    .uart_int (uart_int)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        bw, cw, tw;
    logic [15:0] wdat;
    logic [15:0] e_con, e_baud, e_txbuf;
    logic        e_en;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic bw, input logic cw, input logic tw, input logic [15:0] d);
    @(negedge sys_clk);
    bus.uart_baud_wr  = bw;
    bus.uart_con_wr   = cw;
    bus.uart_txbuf_wr = tw;
    bus.icb_wdat      = d;
    @(negedge sys_clk);
    bus.uart_baud_wr  = 1'b0;
    bus.uart_con_wr   = 1'b0;
    bus.uart_txbuf_wr = 1'b0;
  endtask

  // Line level j cycles into a frame: start, 8 data LSB first, stop; each bit b+1 cycles.
  function automatic logic exp_tx(input logic [7:0] d, input int j, input int b);
    int idx;
    idx = j / (b + 1);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return d[idx-1];
    else return 1'b1;
  endfunction

  task automatic tx_frame(input logic [7:0] d, input int b, input int inj, input string tag);
    int bad;
    bad = 0;
    @(negedge sys_clk);
    bus.uart_txbuf_wr = 1'b1;
    bus.icb_wdat      = {8'h00, d};
    @(negedge sys_clk);
    bus.uart_txbuf_wr = 1'b0;
    check({tag, "_busy"}, {15'd0, bus.uart_con[13]}, 16'd1);
    for (int j = 0; j < 10 * (b + 1); j++) begin
      if (uart_tx !== exp_tx(d, j, b)) bad++;
      if (j == inj) begin
        bus.uart_txbuf_wr = 1'b1;
        bus.uart_baud_wr  = 1'b1;
        bus.icb_wdat      = 16'h0055;
      end else if (j == inj + 1) begin
        bus.uart_txbuf_wr = 1'b0;
        bus.uart_baud_wr  = 1'b0;
      end
      @(negedge sys_clk);
    end
    check({tag, "_wave_errs"}, bad[15:0], 16'd0);
    check({tag, "_tx_pend"}, {15'd0, bus.uart_con[15]}, 16'd1);
    check({tag, "_busy_end"}, {15'd0, bus.uart_con[13]}, 16'd0);
    check({tag, "_txdata"}, {8'h00, bus.uart_txbuf[7:0]}, {8'h00, d});
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop, input int b);
    for (int i = 0; i < 10; i++) begin
      uart_rx = (i == 0) ? 1'b0 : (i <= 8) ? d[i-1] : stop;
      repeat (b + 1) @(negedge sys_clk);
    end
    uart_rx = 1'b1;
    repeat (b + 6) @(negedge sys_clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [7:0] d;
    int b;

    sys_rst = 1'b1;
    uart_rx = 1'b1;
    bus.uart_baud_wr  = 1'b0;
    bus.uart_con_wr   = 1'b0;
    bus.uart_txbuf_wr = 1'b0;
    bus.icb_wdat      = 16'h0000;
    repeat (30) @(negedge sys_clk);
    check("rst_tx", {15'd0, uart_tx}, 16'd1);
    check("rst_con", bus.uart_con, 16'h0000);
    check("rst_baud", bus.uart_baud, 16'h0000);
    check("rst_txbuf", bus.uart_txbuf, 16'h0000);
    check("rst_en", {15'd0, uart_en}, 16'd0);
    check("rst_int", {15'd0, uart_int}, 16'd0);
    sys_rst = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0006, 16'h1234, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h12AB, 16'h0006, 16'h1234, 16'h00AB, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h00AB, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0C35, 16'h0005, 16'h0C35, 16'h0035, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0C35, 16'h0035, 1'b0};
    for (int i = 0; i < 6; i++) begin
      bus_write(vecs[i].bw, vecs[i].cw, vecs[i].tw, vecs[i].wdat);
      check($sformatf("vec%0d_con", i), bus.uart_con, vecs[i].e_con);
      check($sformatf("vec%0d_baud", i), bus.uart_baud, vecs[i].e_baud);
      check($sformatf("vec%0d_txbuf", i), bus.uart_txbuf, vecs[i].e_txbuf);
      check($sformatf("vec%0d_en", i), {15'd0, uart_en}, {15'd0, vecs[i].e_en});
      check($sformatf("vec%0d_tx", i), {15'd0, uart_tx}, 16'd1);
    end

    // 0x07 frame; 0x55 txbuf and baud writes land mid-frame and must not disturb it
    bus_write(1'b1, 1'b0, 1'b0, 16'd3);
    bus_write(1'b0, 1'b1, 1'b0, 16'h0001);
    tx_frame(8'h07, 3, 12, "tx07");
    @(negedge sys_clk);
    check("tx07_int_off", {15'd0, uart_int}, 16'd0);
    check("tx07_baud_new", bus.uart_baud, 16'h0055);
    bus_write(1'b1, 1'b0, 1'b0, 16'd3);

    bus_write(1'b0, 1'b1, 1'b0, 16'h8003);
    check("txie_pend_clr", {15'd0, bus.uart_con[15]}, 16'd0);
    tx_frame(8'h07, 3, -5, "txie");
    check("txie_int_lag", {15'd0, uart_int}, 16'd0);
    @(negedge sys_clk);
    check("txie_int_set", {15'd0, uart_int}, 16'd1);
    bus_write(1'b0, 1'b1, 1'b0, 16'h8003);
    check("w1c_pend", {15'd0, bus.uart_con[15]}, 16'd0);
    check("w1c_int_lag", {15'd0, uart_int}, 16'd1);
    @(negedge sys_clk);
    check("w1c_int_clr", {15'd0, uart_int}, 16'd0);

    for (int n = 0; n < 6; n++) begin
      b = $urandom_range(0, 5);
      d = 8'($urandom);
      bus_write(1'b1, 1'b0, 1'b0, 16'(b));
      tx_frame(d, b, -5, $sformatf("rtx%0d", n));
      bus_write(1'b0, 1'b1, 1'b0, 16'h8003);
    end

    // abort: clearing en mid-frame returns the line high at once and sets no flag
    bus_write(1'b1, 1'b0, 1'b0, 16'd3);
    bus_write(1'b0, 1'b1, 1'b0, 16'h0001);
    @(negedge sys_clk);
    bus.uart_txbuf_wr = 1'b1;
    bus.icb_wdat      = 16'h00F0;
    @(negedge sys_clk);
    bus.uart_txbuf_wr = 1'b0;
    repeat (10) @(negedge sys_clk);
    bus_write(1'b0, 1'b1, 1'b0, 16'h0000);
    check("abort_tx", {15'd0, uart_tx}, 16'd1);
    check("abort_busy", {15'd0, bus.uart_con[13]}, 16'd0);
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      if (uart_tx !== 1'b1) bad++;
      @(negedge sys_clk);
    end
    check("abort_line_idle", bad[15:0], 16'd0);
    check("abort_no_pend", {15'd0, bus.uart_con[15]}, 16'd0);

    // synchronous reset mid-frame
    bus_write(1'b0, 1'b1, 1'b0, 16'h0001);
    @(negedge sys_clk);
    bus.uart_txbuf_wr = 1'b1;
    bus.icb_wdat      = 16'h0000;
    @(negedge sys_clk);
    bus.uart_txbuf_wr = 1'b0;
    repeat (6) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("mrst_tx", {15'd0, uart_tx}, 16'd1);
    check("mrst_con", bus.uart_con, 16'h0000);
    check("mrst_baud", bus.uart_baud, 16'h0000);
    check("mrst_txbuf", bus.uart_txbuf, 16'h0000);

    // receive path
    bus_write(1'b1, 1'b0, 1'b0, 16'd3);
    bus_write(1'b0, 1'b1, 1'b0, 16'h0005);
    rx_frame(8'hA5, 1'b1, 3);
    check("rxA5_data", {8'h00, bus.uart_txbuf[15:8]}, 16'h00A5);
    check("rxA5_pend", {15'd0, bus.uart_con[14]}, 16'd1);
    check("rxA5_int", {15'd0, uart_int}, 16'd1);
    bus_write(1'b0, 1'b1, 1'b0, 16'h4005);
    check("rx_pend_clr", {15'd0, bus.uart_con[14]}, 16'd0);

    uart_rx = 1'b0;
    repeat (2) @(negedge sys_clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge sys_clk);
    check("glitch_pend", {15'd0, bus.uart_con[14]}, 16'd0);
    check("glitch_ferr", {15'd0, bus.uart_con[12]}, 16'd0);
    rx_frame(8'h3C, 1'b1, 3);
    check("rx3C_data", {8'h00, bus.uart_txbuf[15:8]}, 16'h003C);
    check("rx3C_pend", {15'd0, bus.uart_con[14]}, 16'd1);

    rx_frame(8'h99, 1'b0, 3);
    check("ferr_set", {15'd0, bus.uart_con[12]}, 16'd1);
    check("ferr_data_kept", {8'h00, bus.uart_txbuf[15:8]}, 16'h003C);
    check("ferr_pend_kept", {15'd0, bus.uart_con[14]}, 16'd1);
    bus_write(1'b0, 1'b1, 1'b0, 16'h5005);
    check("ferr_clr", {12'd0, bus.uart_con[15:12]}, 16'h0000);

    for (int n = 0; n < 5; n++) begin
      b = $urandom_range(0, 5);
      d = 8'($urandom);
      bus_write(1'b1, 1'b0, 1'b0, 16'(b));
      rx_frame(d, 1'b1, b);
      check($sformatf("rrx%0d_data", n), {8'h00, bus.uart_txbuf[15:8]}, {8'h00, d});
      check($sformatf("rrx%0d_pend", n), {15'd0, bus.uart_con[14]}, 16'd1);
      bus_write(1'b0, 1'b1, 1'b0, 16'h4005);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
